rvc_asap_5pl_vga_mem_arb: RTL and testbench

Arbiter that shares the single-port VGA frame memory between the rvc_asap_5pl core's load/store port and the VGA display fetch engine inside the memory wrapper. Each cycle it grants at most one requester, drives the memory port, and returns read data one cycle later on the winner's response channel. The display has priority so scanout deadlines are met, and a bounded-run rule keeps the core from starving. The frame memory stays passive; all sequencing lives here.

---
 rtl/rvc_asap_5pl_vga_mem_arb.sv | 128 ++++++++++++
 tb/tb_rvc_asap_5pl_vga_mem_arb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rvc_asap_5pl_vga_mem_arb.sv
// Arbiter sharing the single-port VGA frame memory between the core load/store port and display fetch.
// Optional statistics counters are built only when RVC_VGA_ARB_STATS_EN is defined.
module rvc_asap_5pl_vga_mem_arb #(
  parameter int ADDR_W       = 16,
  parameter int MAX_DISP_RUN = 4
) (
  input  logic              Clock,
  input  logic              Rst,
  input  logic              CoreReqValid,
  input  logic              CoreReqWr,
  input  logic [ADDR_W-1:0] CoreReqAddr,
  input  logic [31:0]       CoreReqWrData,
  input  logic [3:0]        CoreReqByteEn,
  output logic              CoreReqReady,
  output logic              CoreRspValid,
  output logic [31:0]       CoreRspData,
  input  logic              DispReqValid,
  input  logic [ADDR_W-1:0] DispReqAddr,
  output logic              DispReqReady,
  output logic              DispRspValid,
  output logic [31:0]       DispRspData,
  output logic              MemEn,
  output logic [3:0]        MemWrEn,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWrData,
  input  logic [31:0]       MemRdData,
  output logic [15:0]       StatCoreStall,
  output logic [15:0]       StatDispGrant
);

  typedef enum logic {DISP_PRI, CORE_PRI} arb_state_e;

  localparam logic [3:0] RUN_MAX = 4'(MAX_DISP_RUN);

  arb_state_e state, state_nxt;
  logic [3:0] run_cnt, run_cnt_nxt;
  logic       core_gnt, disp_gnt;
  logic       rsp_vld, rsp_core;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    core_gnt = 1'b0;
    disp_gnt = 1'b0;
    if (!Rst) begin
      if (CoreReqValid && DispReqValid) begin
        if (state == CORE_PRI) core_gnt = 1'b1;
        else                   disp_gnt = 1'b1;
      end else begin
        core_gnt = CoreReqValid;
        disp_gnt = DispReqValid;
      end
    end
  end

  // The run counter only measures display grants that actually made the core wait.
  always_comb begin
    state_nxt   = state;
    run_cnt_nxt = run_cnt;
    if (core_gnt || !CoreReqValid) begin
      run_cnt_nxt = '0;
      state_nxt   = DISP_PRI;
    end else if (disp_gnt) begin
      run_cnt_nxt = run_cnt + 4'd1;
      if (run_cnt_nxt == RUN_MAX) state_nxt = CORE_PRI;
    end
  end

  always_comb begin
    MemEn     = core_gnt | disp_gnt;
    MemWrEn   = '0;
    MemAddr   = '0;
    MemWrData = '0;
    if (core_gnt) begin
      MemAddr = CoreReqAddr;
      if (CoreReqWr) begin
        MemWrEn   = CoreReqByteEn;
        MemWrData = CoreReqWrData;
      end
    end else if (disp_gnt) begin
      MemAddr = DispReqAddr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      state    <= DISP_PRI;
      run_cnt  <= '0;
      rsp_vld  <= 1'b0;
      rsp_core <= 1'b0;
    end else begin
      state    <= state_nxt;
      run_cnt  <= run_cnt_nxt;
      rsp_vld  <= disp_gnt || (core_gnt && !CoreReqWr);
      rsp_core <= core_gnt;
    end
  end

  assign CoreReqReady = core_gnt;
  assign DispReqReady = disp_gnt;
  assign CoreRspValid = rsp_vld && rsp_core;
  assign DispRspValid = rsp_vld && !rsp_core;
  assign CoreRspData  = CoreRspValid ? MemRdData : '0;
  assign DispRspData  = DispRspValid ? MemRdData : '0;

`ifdef RVC_VGA_ARB_STATS_EN
  logic [15:0] stat_core_stall, stat_disp_grant;

  always_ff @(posedge Clock) begin
    if (Rst) begin
      stat_core_stall <= '0;
      stat_disp_grant <= '0;
    end else begin
      if (CoreReqValid && !core_gnt && stat_core_stall != 16'hFFFF)
        stat_core_stall <= stat_core_stall + 16'd1;
      if (disp_gnt && stat_disp_grant != 16'hFFFF)
        stat_disp_grant <= stat_disp_grant + 16'd1;
    end
  end

  assign StatCoreStall = stat_core_stall;
  assign StatDispGrant = stat_disp_grant;
`else
  assign StatCoreStall = '0;
  assign StatDispGrant = '0;
`endif

endmodule

// File: tb/tb_rvc_asap_5pl_vga_mem_arb.sv
// Self-checking bench for rvc_asap_5pl_vga_mem_arb: vector table, reset and contention sequences,
// read responses tracked through a scoreboard queue against a behavioural frame memory.
module tb_rvc_asap_5pl_vga_mem_arb;

  localparam int MAX_RUN = 4;

  typedef struct {
    logic        rst, cv, cw;
    logic [15:0] ca;
    logic [31:0] cd;
    logic [3:0]  cbe;
    logic        dv;
    logic [15:0] da;
    logic        xc, xd, xen;
    logic [3:0]  xwe;
    logic [15:0] xaddr;
    logic [31:0] xwd;
    int          rk;    // expected response next cycle: 0 none, 1 core, 2 display
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    int          rk;
    logic [31:0] rd;
  } rsp_t;

  logic        Clock = 1'b0;
  logic        Rst, CoreReqValid, CoreReqWr, DispReqValid;
  logic [15:0] CoreReqAddr, DispReqAddr, MemAddr;
  logic [31:0] CoreReqWrData, CoreRspData, DispRspData, MemWrData, MemRdData;
  logic [3:0]  CoreReqByteEn, MemWrEn;
  logic        CoreReqReady, CoreRspValid, DispReqReady, DispRspValid, MemEn;
  logic [15:0] StatCoreStall, StatDispGrant;

  int total = 0;
  int bad   = 0;
  rsp_t sb[$];
  logic [31:0] mem [0:1023];

  rvc_asap_5pl_vga_mem_arb #(.ADDR_W(16), .MAX_DISP_RUN(MAX_RUN)) dut (
    .Clock(Clock), .Rst(Rst),
    .CoreReqValid(CoreReqValid), .CoreReqWr(CoreReqWr), .CoreReqAddr(CoreReqAddr),
    .CoreReqWrData(CoreReqWrData), .CoreReqByteEn(CoreReqByteEn), .CoreReqReady(CoreReqReady),
    .CoreRspValid(CoreRspValid), .CoreRspData(CoreRspData),
    .DispReqValid(DispReqValid), .DispReqAddr(DispReqAddr), .DispReqReady(DispReqReady),
    .DispRspValid(DispRspValid), .DispRspData(DispRspData),
    .MemEn(MemEn), .MemWrEn(MemWrEn), .MemAddr(MemAddr), .MemWrData(MemWrData),
    .MemRdData(MemRdData), .StatCoreStall(StatCoreStall), .StatDispGrant(StatDispGrant)
  );

  always #5 Clock = ~Clock;

  // Behavioural single-port frame memory: byte-enabled writes, registered reads.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE, 16'(i)};
    mem[16'h10] = 32'hDEADBEEF;
    mem[16'h20] = 32'h11223344;
    MemRdData = '0;
    forever begin
      @(posedge Clock);
      if (MemEn) begin
        if (MemWrEn == 4'b0000) MemRdData <= mem[MemAddr[9:0]];
        else
          for (int b = 0; b < 4; b++)
            if (MemWrEn[b]) mem[MemAddr[9:0]][b*8 +: 8] <= MemWrData[b*8 +: 8];
      end
    end
  end

  function automatic logic [31:0] init_word(input logic [15:0] a);
    return {16'hC0DE, a};
  endfunction

  function automatic vec_t mk(input logic rst, cv, cw, input logic [15:0] ca,
                              input logic [31:0] cd, input logic [3:0] cbe,
                              input logic dv, input logic [15:0] da,
                              input logic xc, xd, input logic [3:0] xwe,
                              input logic [15:0] xaddr, input logic [31:0] xwd,
                              input int rk, input logic [31:0] rd);
    vec_t v;
    v.rst = rst; v.cv = cv; v.cw = cw; v.ca = ca; v.cd = cd; v.cbe = cbe;
    v.dv = dv; v.da = da; v.xc = xc; v.xd = xd; v.xen = xc | xd;
    v.xwe = xwe; v.xaddr = xaddr; v.xwd = xwd; v.rk = rk; v.rd = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drives one cycle, checks grants/memory port and the previous cycle's response.
  task automatic apply(input vec_t v);
    rsp_t r;
    Rst = v.rst; CoreReqValid = v.cv; CoreReqWr = v.cw; CoreReqAddr = v.ca;
    CoreReqWrData = v.cd; CoreReqByteEn = v.cbe; DispReqValid = v.dv; DispReqAddr = v.da;
    #1;
    if (sb.size() > 0) begin
      r = sb.pop_front();
      check("core_rsp_valid", 32'(CoreRspValid), 32'(r.rk == 1));
      check("disp_rsp_valid", 32'(DispRspValid), 32'(r.rk == 2));
      check("core_rsp_data", CoreRspData, (r.rk == 1) ? r.rd : 32'h0);
      check("disp_rsp_data", DispRspData, (r.rk == 2) ? r.rd : 32'h0);
    end
    check("core_ready", 32'(CoreReqReady), 32'(v.xc));
    check("disp_ready", 32'(DispReqReady), 32'(v.xd));
    check("mem_en", 32'(MemEn), 32'(v.xen));
    check("mem_wr_en", 32'(MemWrEn), 32'(v.xwe));
    check("mem_addr", 32'(MemAddr), 32'(v.xaddr));
    check("mem_wr_data", MemWrData, v.xwd);
    r.rk = v.rk;
    r.rd = v.rd;
    sb.push_back(r);
    @(negedge Clock);
  endtask

  vec_t idle_v, rst_v;
  vec_t tbl[12];

  initial begin
    int d_cnt;
    logic [15:0] d_addr;
    logic [31:0] exp_stat;
    vec_t v;

    idle_v = mk(0, 0, 0, 16'h0, 32'h0, 4'h0, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0, 0, 32'h0);
    rst_v  = mk(1, 0, 0, 16'h0, 32'h0, 4'h0, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0, 0, 32'h0);

    //             rst cv cw ca        cd            cbe   dv da        xc xd xwe   xaddr     xwd           rk rd
    tbl[0]  = mk(0, 0, 0, 16'h0000, 32'h0,        4'h0, 0, 16'h0000, 0, 0, 4'h0, 16'h0000, 32'h0,        0, 32'h0);
    tbl[1]  = mk(0, 1, 0, 16'h0010, 32'h0,        4'h0, 0, 16'h0000, 1, 0, 4'h0, 16'h0010, 32'h0,        1, 32'hDEADBEEF);
    tbl[2]  = mk(0, 1, 1, 16'h0020, 32'hA5A5A5A5, 4'h3, 0, 16'h0000, 1, 0, 4'h3, 16'h0020, 32'hA5A5A5A5, 0, 32'h0);
    tbl[3]  = mk(0, 1, 0, 16'h0020, 32'h0,        4'h0, 0, 16'h0000, 1, 0, 4'h0, 16'h0020, 32'h0,        1, 32'h1122A5A5);
    tbl[4]  = mk(0, 0, 0, 16'h0000, 32'h0,        4'h0, 1, 16'h0030, 0, 1, 4'h0, 16'h0030, 32'h0,        2, 32'hC0DE0030);
    tbl[5]  = mk(0, 1, 0, 16'h0040, 32'h0,        4'h0, 1, 16'h0031, 0, 1, 4'h0, 16'h0031, 32'h0,        2, 32'hC0DE0031);
    tbl[6]  = mk(0, 1, 0, 16'h0040, 32'h0,        4'h0, 0, 16'h0000, 1, 0, 4'h0, 16'h0040, 32'h0,        1, 32'hC0DE0040);
    tbl[7]  = mk(0, 1, 1, 16'h0050, 32'h12345678, 4'hF, 1, 16'h0032, 0, 1, 4'h0, 16'h0032, 32'h0,        2, 32'hC0DE0032);
    tbl[8]  = mk(0, 1, 1, 16'h0050, 32'h12345678, 4'hF, 0, 16'h0000, 1, 0, 4'hF, 16'h0050, 32'h12345678, 0, 32'h0);
    tbl[9]  = mk(0, 1, 0, 16'h0050, 32'h0,        4'h0, 0, 16'h0000, 1, 0, 4'h0, 16'h0050, 32'h0,        1, 32'h12345678);
    tbl[10] = mk(0, 0, 0, 16'h0000, 32'h0,        4'h0, 1, 16'h0033, 0, 1, 4'h0, 16'h0033, 32'h0,        2, 32'hC0DE0033);
    tbl[11] = mk(0, 0, 0, 16'h0000, 32'h0,        4'h0, 0, 16'h0000, 0, 0, 4'h0, 16'h0000, 32'h0,        0, 32'h0);

    @(negedge Clock);
    apply(rst_v);
    apply(rst_v);
    check("reset_stat_core_stall", 32'(StatCoreStall), 32'h0);
    check("reset_stat_disp_grant", 32'(StatDispGrant), 32'h0);

    for (int i = 0; i < 12; i++) apply(tbl[i]);

    // Reset while the display is requesting: no grant, no response, then normal service.
    apply(mk(1, 0, 0, 16'h0, 32'h0, 4'h0, 1, 16'h0034, 0, 0, 4'h0, 16'h0000, 32'h0, 0, 32'h0));
    check("midrst_stat_core_stall", 32'(StatCoreStall), 32'h0);
    check("midrst_stat_disp_grant", 32'(StatDispGrant), 32'h0);
    apply(idle_v);
    apply(mk(0, 0, 0, 16'h0, 32'h0, 4'h0, 1, 16'h0035, 0, 1, 4'h0, 16'h0035, 32'h0, 2, 32'hC0DE0035));
    apply(idle_v);

    // Core alone, eight back-to-back reads.
    for (int i = 0; i < 8; i++) begin
      v = mk(0, 1, 0, 16'h0060 + 16'(i), 32'h0, 4'h0, 0, 16'h0, 1, 0, 4'h0,
             16'h0060 + 16'(i), 32'h0, 1, init_word(16'h0060 + 16'(i)));
      apply(v);
    end

    // Fresh reset, then both requesters continuously valid for 50 cycles.
    apply(rst_v);
    d_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      d_addr = 16'h0100 + 16'(d_cnt);
      if ((k % (MAX_RUN + 1)) != MAX_RUN) begin
        v = mk(0, 1, 0, 16'h0040, 32'h0, 4'h0, 1, d_addr, 0, 1, 4'h0, d_addr, 32'h0, 2, init_word(d_addr));
        d_cnt++;
      end else begin
        v = mk(0, 1, 0, 16'h0040, 32'h0, 4'h0, 1, d_addr, 1, 0, 4'h0, 16'h0040, 32'h0, 1, init_word(16'h0040));
      end
      apply(v);
    end
    apply(idle_v);
`ifdef RVC_VGA_ARB_STATS_EN
    exp_stat = 32'd40;
`else
    exp_stat = 32'd0;
`endif
    check("stat_disp_grant", 32'(StatDispGrant), exp_stat);
    check("stat_core_stall", 32'(StatCoreStall), exp_stat);
    apply(idle_v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
